// File: rtl/nn_pkg.sv
// Shared definitions for the 784-20-20-10 forward-pass scheduler.
//   - Layer size constants N_IN / N_H1 / N_H2 / N_OUT.
//   - One-hot layer encoding (LNone when no layer is active).
//   - Scheduler state enum.
//   - Helpers returning the input count and neuron count of a layer.
package nn_pkg;

   localparam int unsigned N_IN  = 784;
   localparam int unsigned N_H1  = 20;
   localparam int unsigned N_H2  = 20;
   localparam int unsigned N_OUT = 10;

   // Widest input vector and largest neuron count across the three layers
   localparam int unsigned MaxInputs  = (N_IN > N_H1) ? ((N_IN > N_H2) ? N_IN : N_H2)
                                                      : ((N_H1 > N_H2) ? N_H1 : N_H2);
   localparam int unsigned MaxNeurons = (N_H1 > N_H2) ? ((N_H1 > N_OUT) ? N_H1 : N_OUT)
                                                      : ((N_H2 > N_OUT) ? N_H2 : N_OUT);
   localparam int unsigned IdxW = $clog2(MaxInputs);
   localparam int unsigned NrnW = $clog2(MaxNeurons);

   typedef enum logic [2:0] {
      LNone = 3'b000,
      L1    = 3'b001,
      L2    = 3'b010,
      L3    = 3'b100
   } layer_e;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StIssue,
      StDrain,
      StWrite,
      StDone
   } sched_state_e;

   function automatic int unsigned layer_inputs(layer_e l);
      case (l)
         L2:      return N_H1;
         L3:      return N_H2;
         default: return N_IN;
      endcase
   endfunction

   function automatic int unsigned layer_neurons(layer_e l);
      case (l)
         L2:      return N_H2;
         L3:      return N_OUT;
         default: return N_H1;
      endcase
   endfunction

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth shift register that delays the issue-valid flag by Depth cycles
// so it lines up with the operand pair arriving at the MAC.
// Ports:
//   Clk     - clock, rising edge
//   Reset_n - asynchronous active-low reset, clears the line
//   Hold    - freeze every stage (no shift, no load)
//   Din     - issue-valid in
//   Dout    - issue-valid delayed by Depth cycles
module valid_delay #(
   parameter int unsigned Depth = 3
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Hold,
   input  logic Din,
   output logic Dout
);

   logic [Depth-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (!Hold) begin
         sr_d[0] = Din;
         for (int i = 1; i < Depth; i++) begin
            sr_d[i] = sr_q[i-1];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign Dout = sr_q[Depth-1];

endmodule

// File: rtl/layer_mac_scheduler.sv
// Sequences the shared MAC datapath through the 784-20-20-10 forward pass,
// one neuron at a time: CLR (load bias), ISSUE (N operand reads), DRAIN
// (wait MAC_LAT for the pipeline), WRITE (store activated result).
// Optional build macro: MAC_SCHED_STALL_EN adds a Stall input that freezes
// the scheduler and masks its strobes while high.
// Ports:
//   Clk, Reset_n     - clock and asynchronous active-low reset
//   Stall            - (MAC_SCHED_STALL_EN only) hold everything this cycle
//   Start            - level request, accepted only in IDLE
//   Busy, Done       - pass in progress / one-cycle completion pulse
//   Layer            - one-hot active layer, 000 when idle or done
//   In_Addr, Wt_Addr - input activation and weight read addresses
//   Mac_Clr, Mac_En  - accumulator clear / accumulate strobes
//   Wr_En, Wr_Addr   - output buffer write strobe and neuron index
//   Relu_En          - apply ReLU on this write (layers 1-2)
module layer_mac_scheduler
   import nn_pkg::*;
#(
   parameter int unsigned MAC_LAT = 3
) (
   input  logic        Clk,
   input  logic        Reset_n,
`ifdef MAC_SCHED_STALL_EN
   input  logic        Stall,
`endif
   input  logic        Start,
   output logic        Busy,
   output logic        Done,
   output logic [2:0]  Layer,
   output logic [9:0]  In_Addr,
   output logic [13:0] Wt_Addr,
   output logic        Mac_Clr,
   output logic        Mac_En,
   output logic        Wr_En,
   output logic [4:0]  Wr_Addr,
   output logic        Relu_En
);

   localparam int unsigned DrW = $clog2(MAC_LAT + 1);

   sched_state_e      state_q, state_d;
   layer_e            layer_q, layer_d;
   logic [NrnW-1:0]   neuron_q, neuron_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [13:0]       wt_q, wt_d;
   logic [DrW-1:0]    drain_q, drain_d;
   logic [IdxW-1:0]   last_idx;
   logic [NrnW-1:0]   last_nrn;
   logic              hold;
   logic              mac_dly;

`ifdef MAC_SCHED_STALL_EN
   assign hold = Stall;
`else
   assign hold = 1'b0;
`endif

   assign last_idx = IdxW'(layer_inputs(layer_q) - 1);
   assign last_nrn = NrnW'(layer_neurons(layer_q) - 1);

   // wt_q walks neuron*N + idx incrementally: it rests on the last weight of
   // a neuron during DRAIN/WRITE, so +1 lands on the next neuron's base.
   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      neuron_d = neuron_q;
      idx_d    = idx_q;
      wt_d     = wt_q;
      drain_d  = drain_q;
      if (!hold) begin
         case (state_q)
            StIdle: begin
               if (Start) begin
                  state_d  = StClr;
                  layer_d  = L1;
                  neuron_d = '0;
                  idx_d    = '0;
                  wt_d     = '0;
               end
            end
            StClr: state_d = StIssue;
            StIssue: begin
               if (idx_q == last_idx) begin
                  state_d = StDrain;
                  drain_d = '0;
               end else begin
                  idx_d = idx_q + IdxW'(1);
                  wt_d  = wt_q + 14'd1;
               end
            end
            StDrain: begin
               if (drain_q == DrW'(MAC_LAT - 1)) begin
                  state_d = StWrite;
               end else begin
                  drain_d = drain_q + DrW'(1);
               end
            end
            StWrite: begin
               idx_d = '0;
               if (neuron_q != last_nrn) begin
                  neuron_d = neuron_q + NrnW'(1);
                  wt_d     = wt_q + 14'd1;
                  state_d  = StClr;
               end else if (layer_q == L3) begin
                  layer_d = LNone;
                  state_d = StDone;
               end else begin
                  layer_d  = layer_e'({layer_q[1:0], 1'b0});
                  neuron_d = '0;
                  wt_d     = '0;
                  state_d  = StClr;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= StIdle;
         layer_q  <= LNone;
         neuron_q <= '0;
         idx_q    <= '0;
         wt_q     <= '0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         neuron_q <= neuron_d;
         idx_q    <= idx_d;
         wt_q     <= wt_d;
         drain_q  <= drain_d;
      end
   end

   valid_delay #(
      .Depth (MAC_LAT)
   ) u_valid_delay (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Hold    (hold),
      .Din     (state_q == StIssue),
      .Dout    (mac_dly)
   );

   assign Busy    = (state_q != StIdle);
   assign Done    = (state_q == StDone) && !hold;
   assign Mac_Clr = (state_q == StClr) && !hold;
   assign Wr_En   = (state_q == StWrite) && !hold;
   assign Mac_En  = mac_dly && !hold;
   assign Relu_En = Wr_En && (layer_q != L3);
   assign Layer   = layer_q;
   assign In_Addr = idx_q;
   assign Wt_Addr = wt_q;
   assign Wr_Addr = neuron_q;

endmodule

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
- Sequences the single shared MAC datapath through the 784-20-20-10 forward pass, one neuron at a time.
- Per neuron: clears the accumulator, issues input and weight read addresses, and waits out the read/multiply pipeline.
- Then writes the activated result to the layer output buffer.
- Sits between the top-level compute control (Start/Done handshake) and the activation/weight memories plus MAC unit.

Parameters:
- N_IN, 784, layer 1 input count
- N_H1, 20, layer 1 neurons (layer 2 input count)
- N_H2, 20, layer 2 neurons (layer 3 input count)
- N_OUT, 10, layer 3 neurons
- MAC_LAT, 3, cycles from address issue to the operand pair arriving at the MAC (memory read + multiply register); valid range 1..8

Ports:
- Clk  in  1  clock, all logic on rising edge
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  level request; accepted only in IDLE
- Busy  out  1  high from the cycle after acceptance through the DONE cycle
- Done  out  1  one-cycle pulse when the final layer-3 write has completed
- Layer  out  3  one-hot active layer: 001, 010 or 100; 000 when idle
- In_Addr  out  10  input activation read address (index within the current layer's input vector)
- Wt_Addr  out  14  weight read address within the current layer's bank: neuron*N_in_layer + input index
- Mac_Clr  out  1  clear accumulator (loads bias)
- Mac_En  out  1  accumulate the operand pair now present at the MAC
- Wr_En  out  1  write accumulator result to the output buffer
- Wr_Addr  out  5  neuron index for the write
- Relu_En  out  1  apply ReLU on this write: 1 for layers 1-2, 0 for layer 3

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State IDLE; all counters 0; delay line cleared.
  - All outputs 0; Layer=000.
  - Reset mid-pass aborts immediately, with no Done and no further writes.
- States: IDLE, CLR, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - Start=1 at an edge goes to CLR with Layer=001, neuron=0, Busy=1.
  - Start while not in IDLE is ignored. A Start still high on return to IDLE starts a new pass.
- CLR: one cycle. Mac_Clr=1, input index=0, Wt_Addr=neuron*N. Then go to ISSUE.
- ISSUE: N cycles, where N = N_IN, N_H1, N_H2 for layers 1, 2, 3.
  - Each cycle issues In_Addr=idx and Wt_Addr=neuron*N+idx.
  - idx increments each cycle.
  - After idx=N-1, go to DRAIN.
- Mac_En: the issue-valid flag delayed by exactly MAC_LAT cycles through the delay line. It therefore asserts exactly N times per neuron, never in CLR or WRITE.
- DRAIN: MAC_LAT cycles; no new issue. The last Mac_En occurs in the final DRAIN cycle.
- WRITE: one cycle. Wr_En=1, Wr_Addr=neuron, Relu_En per layer. Next state:
  - Not the last neuron of the layer: neuron++ and go to CLR.
  - Last neuron of layer 1 or 2: shift Layer left, neuron=0, go to CLR.
  - Last neuron of layer 3: go to DONE.
- DONE: one cycle. Done=1, Busy=1, Layer=000. Then go to IDLE.
- Address outputs are registered. In_Addr/Wt_Addr hold their last value outside ISSUE; they are don't-care for consumers.
- Per-neuron cost is N+MAC_LAT+2 cycles. With defaults:
  - layer 1: 20*789 = 15780 cycles
  - layer 2: 20*25 = 500 cycles
  - layer 3: 10*25 = 250 cycles
  - Start accepted at edge k gives Done high in cycle k+16531.
- Widths:
  - Wt_Addr max 20*784-1 = 15679, which fits in 14 bits.
  - Counters are sized from parameters with $clog2 and never wrap within a pass.

Optional Feature:
- Macro: MAC_SCHED_STALL_EN.
- When defined:
  - Adds input Stall (1 bit).
  - While Stall=1, state, counters and delay line hold, and Mac_Clr/Mac_En/Wr_En/Done are forced to 0.
  - Outputs resume unchanged on the cycle after Stall falls.
  - Total latency grows by exactly the number of stalled cycles.
  - Stall in IDLE delays Start acceptance.
- When undefined: no Stall port; behaviour is as above.

Decomposition:
- Package nn_pkg holds:
  - the layer size constants N_IN/N_H1/N_H2/N_OUT;
  - the one-hot layer typedef with values L1=001, L2=010, L3=100, NONE=000;
  - the scheduler state enum.
- One sub-module, valid_delay, a parameterised MAC_LAT-deep shift register with stall hold, generates Mac_En.

Test Plan:
- Reset, then Start pulse at cycle 10 -> Busy from cycle 11; Done single pulse at cycle 16541; Layer sequence 001 -> 010 -> 100 -> 000.
- Count per layer -> Mac_Clr = 20/20/10; Mac_En = 15680/400/200; Wr_En = 20/20/10 with Wr_Addr 0..19, 0..19, 0..9; Relu_En=0 only on layer 3.
- Layer 2, neuron 5 -> Wt_Addr sweeps 100..119 and In_Addr 0..19; first Mac_En exactly 3 cycles after first issue; Wr_En one cycle after last Mac_En.
- Start toggled during Busy, and Start held high across DONE -> the held Start is ignored while Busy and starts a second pass on the first IDLE cycle; Done counts exactly 2.
- Reset_n low mid-layer 1 (cycle 5000) -> all outputs 0 asynchronously; no Done; a new Start gives full-length latency.
- MAC_SCHED_STALL_EN: Stall high for 7 cycles during DRAIN -> Mac_En count unchanged; Done delayed by exactly 7 cycles.
